// File: rtl/imem_controller.sv
// rtl/imem_controller.sv - instruction memory sequencer: zero-fill sweep, loader/fetch arbitration
// Optional misaligned-fetch trap enabled by defining IMEM_MISALIGN_TRAP_EN.
module imem_controller #(
  parameter int          DEPTH    = 1024,
  parameter int          AW       = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_rewind,
  output logic          ld_ready,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_stall,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
`ifdef IMEM_MISALIGN_TRAP_EN
  ,
  output logic          fetch_err
`endif
);

  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic [AW-1:0] ld_ptr, ld_ptr_nxt;
  logic          fetch_go;

  // Only the word-index bits of the byte address select a memory word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ld_ptr_nxt  = ld_rewind ? '0 : ld_ptr;
    mem_we      = 1'b0;
    mem_wdata   = 32'h0;
    mem_addr    = fetch_addr[AW+1:2];
    ld_ready    = 1'b0;
    fetch_stall = fetch_req;
    busy        = 1'b0;
    fetch_go    = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we      = 1'b1;
        mem_addr    = clr_cnt;
        busy        = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state_nxt = S_SERVE;
      end
      default: begin
        if (clear_req) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
        end else if (ld_valid) begin
          mem_we     = 1'b1;
          mem_addr   = ld_ptr;
          mem_wdata  = ld_data;
          ld_ready   = 1'b1;
          ld_ptr_nxt = ld_rewind ? '0 : ld_ptr + 1'b1;
        end else if (fetch_req) begin
          fetch_stall = 1'b0;
          fetch_go    = 1'b1;
        end
      end
    endcase
    // While reset is held the memory must not be written and the PC must hold.
    if (!rst) begin
      mem_we      = 1'b0;
      ld_ready    = 1'b0;
      busy        = 1'b1;
      fetch_stall = 1'b1;
      fetch_go    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      ld_ptr      <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= NOP_WORD;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      ld_ptr      <= ld_ptr_nxt;
      fetch_valid <= fetch_go;
      if (fetch_go) begin
`ifdef IMEM_MISALIGN_TRAP_EN
        fetch_instr <= (fetch_addr[1:0] != 2'b00) ? NOP_WORD : mem_rdata;
`else
        fetch_instr <= mem_rdata;
`endif
      end
    end
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_err <= 1'b0;
    else      fetch_err <= fetch_go && (fetch_addr[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_imem_controller.sv
// tb/tb_imem_controller.sv - randomized self-checking bench for imem_controller (DEPTH=16)
module tb_imem_controller;
  localparam int D = 16;
  localparam int A = 4;

  logic          clk = 1'b0;
  logic          rst, clear_req, ld_valid, ld_rewind, fetch_req;
  logic [31:0]   ld_data, fetch_addr;
  logic          ld_ready, fetch_valid, fetch_stall, busy, mem_we;
  logic [31:0]   fetch_instr, mem_wdata, mem_rdata;
  logic [A-1:0]  mem_addr;
  logic          fetch_err_s;
  logic          fill_ff;
  logic [31:0]   tb_mem [D];

  logic [31:0]   ref_mem [D];
  int            ref_ptr;
  logic [31:0]   ref_fi;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  imem_controller #(.DEPTH(D), .AW(A), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_rewind(ld_rewind), .ld_ready(ld_ready), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_stall(fetch_stall), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef IMEM_MISALIGN_TRAP_EN
    , .fetch_err(fetch_err_s)
`endif
  );
`ifndef IMEM_MISALIGN_TRAP_EN
  assign fetch_err_s = 1'b0;
`endif

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (fill_ff) begin
      for (int i = 0; i < D; i++) tb_mem[i] <= 32'hFFFF_FFFF;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  function automatic logic [31:0] exp_fetch(input logic [31:0] fa);
`ifdef IMEM_MISALIGN_TRAP_EN
    if (fa[1:0] != 2'b00) return 32'h0;
`endif
    return ref_mem[int'((fa >> 2) % 32'(D))];
  endfunction

  function automatic int exp_word(input logic [31:0] fa);
    return int'((fa >> 2) % 32'(D));
  endfunction

  task automatic ref_load(input logic [31:0] d, input logic rw);
    ref_mem[ref_ptr] = d;
    ref_ptr = rw ? 0 : (ref_ptr + 1) % D;
  endtask

  task automatic cyc(input logic cr, input logic lv, input logic [31:0] ld, input logic rw,
                     input logic fr, input logic [31:0] fa,
                     output logic o_ready, output logic o_stall, output logic o_we, output logic o_busy,
                     output logic [A-1:0] o_addr, output logic [31:0] o_wdata,
                     output logic o_fv, output logic [31:0] o_fi, output logic o_err);
    @(negedge clk);
    clear_req = cr; ld_valid = lv; ld_data = ld; ld_rewind = rw; fetch_req = fr; fetch_addr = fa;
    #1;
    o_ready = ld_ready; o_stall = fetch_stall; o_we = mem_we; o_busy = busy;
    o_addr = mem_addr; o_wdata = mem_wdata;
    @(posedge clk);
    #1;
    o_fv = fetch_valid; o_fi = fetch_instr; o_err = fetch_err_s;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_req = 0; ld_valid = 0; ld_data = 0; ld_rewind = 0;
    fetch_req = 1'b1; fetch_addr = 0; fill_ff = 1'b1;
    @(posedge clk); #1 fill_ff = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", fetch_stall); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ld_ready); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", fetch_valid); end
    n_checks++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", fetch_instr); end
  endtask

  task automatic test_zero_fill();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      n_checks++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== A'(i) || mem_wdata !== 32'h0 || fetch_stall !== 1'b1) begin
        n_fail++; $display("FAIL sweep_cycle%0d got busy=%b we=%b addr=%0d wdata=%h stall=%b want 1 1 %0d 0 1", i, busy, mem_we, mem_addr, mem_wdata, fetch_stall, i);
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (busy !== 1'b0 || fetch_stall !== 1'b0) begin n_fail++; $display("FAIL sweep_end got busy=%b stall=%b want 0 0", busy, fetch_stall); end
    fetch_req = 1'b0;
    for (int i = 0; i < D; i++) begin
      n_checks++; if (tb_mem[i] !== 32'h0) begin n_fail++; $display("FAIL zero_word%0d got %h want 0", i, tb_mem[i]); end
      ref_mem[i] = 32'h0;
    end
    ref_ptr = 0; ref_fi = 32'h0;
  endtask

  task automatic test_load_fetch();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    logic [31:0] words [3];
    words[0] = 32'h2008_0005; words[1] = 32'h2009_0003; words[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, words[i], 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (r !== 1'b1 || w !== 1'b1 || ad !== A'(ref_ptr) || wd !== words[i] || fv !== 1'b0) begin
        n_fail++; $display("FAIL load%0d got ready=%b we=%b addr=%0d wdata=%h fv=%b want 1 1 %0d %h 0", i, r, w, ad, wd, fv, ref_ptr, words[i]);
      end
      ref_load(words[i], 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 32'(i * 4), r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (s !== 1'b0 || fv !== 1'b1 || fi !== words[i]) begin
        n_fail++; $display("FAIL fetch%0d got stall=%b fv=%b instr=%h want 0 1 %h", i, s, fv, fi, words[i]);
      end
      ref_fi = words[i];
    end
    cyc(0, 0, 0, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fv !== 1'b0 || fi !== ref_fi) begin n_fail++; $display("FAIL idle_hold got fv=%b instr=%h want 0 %h", fv, fi, ref_fi); end
  endtask

  task automatic test_conflict();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    logic [31:0] fa;
    fa = 32'(ref_ptr * 4);
    cyc(0, 1, 32'h1234_5678, 0, 1, fa, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (r !== 1'b1 || s !== 1'b1 || fv !== 1'b0 || fi !== ref_fi) begin
      n_fail++; $display("FAIL conflict got ready=%b stall=%b fv=%b instr=%h want 1 1 0 %h", r, s, fv, fi, ref_fi);
    end
    ref_load(32'h1234_5678, 1'b0);
    cyc(0, 0, 0, 0, 1, fa, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (s !== 1'b0 || fv !== 1'b1 || fi !== 32'h1234_5678) begin
      n_fail++; $display("FAIL raw_fetch got stall=%b fv=%b instr=%h want 0 1 12345678", s, fv, fi);
    end
    ref_fi = fi;
  endtask

  task automatic test_wrap_rewind();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    cyc(0, 0, 0, 1, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    ref_ptr = 0;
    for (int i = 0; i <= D; i++) begin
      cyc(0, 1, 32'(i), 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (r !== 1'b1 || ad !== A'(ref_ptr)) begin n_fail++; $display("FAIL wrap_load%0d got ready=%b addr=%0d want 1 %0d", i, r, ad, ref_ptr); end
      ref_load(32'(i), 1'b0);
    end
    cyc(0, 0, 0, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fi !== 32'd16) begin n_fail++; $display("FAIL wrap_word0 got %h want 10", fi); end
    cyc(0, 1, 32'hAA, 1, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (r !== 1'b1 || ad !== A'(1)) begin n_fail++; $display("FAIL rewind_write got ready=%b addr=%0d want 1 1", r, ad); end
    ref_load(32'hAA, 1'b1);
    cyc(0, 1, 32'hBB, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (ad !== A'(0)) begin n_fail++; $display("FAIL rewind_next got addr=%0d want 0", ad); end
    ref_load(32'hBB, 1'b0);
    cyc(0, 0, 0, 0, 1, 4, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fi !== 32'hAA) begin n_fail++; $display("FAIL rewind_word1 got %h want aa", fi); end
    cyc(0, 0, 0, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fi !== 32'hBB) begin n_fail++; $display("FAIL rewind_word0 got %h want bb", fi); end
    ref_fi = fi;
  endtask

  task automatic test_alias();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0044; addrs[1] = 32'hFFFF_FF84;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1, addrs[i], r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (ad !== A'(1) || fv !== 1'b1 || fi !== ref_mem[1]) begin
        n_fail++; $display("FAIL alias%0d got addr=%0d fv=%b instr=%h want 1 1 %h", i, ad, fv, fi, ref_mem[1]);
      end
      ref_fi = fi;
    end
  endtask

  task automatic test_random();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    logic lv, rw, fr; logic [31:0] ld, fa, x_fi; logic x_fv, x_err; int x_addr;
    for (int n = 0; n < 300; n++) begin
      lv = ($urandom_range(0, 2) == 0); fr = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 11) == 0); ld = $urandom; fa = $urandom;
      x_fv = fr && !lv;
      x_fi = x_fv ? exp_fetch(fa) : ref_fi;
      x_addr = lv ? ref_ptr : exp_word(fa);
      x_err = 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
      x_err = x_fv && (fa[1:0] != 2'b00);
`endif
      cyc(0, lv, ld, rw, fr, fa, r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (r !== lv || s !== (fr && lv) || w !== lv || ad !== A'(x_addr) || fv !== x_fv || fi !== x_fi || e !== x_err) begin
        n_fail++; $display("FAIL random%0d got ready=%b stall=%b we=%b addr=%0d fv=%b instr=%h err=%b want %b %b %b %0d %b %h %b",
                           n, r, s, w, ad, fv, fi, e, lv, fr && lv, lv, x_addr, x_fv, x_fi, x_err);
      end
      if (lv) ref_load(ld, rw);
      else if (rw) ref_ptr = 0;
      ref_fi = x_fi;
    end
  endtask

  task automatic test_clear();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    cyc(1, 1, 32'h5555_AAAA, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (r !== 1'b0 || s !== 1'b1 || w !== 1'b0 || fv !== 1'b0) begin
      n_fail++; $display("FAIL clear_cycle got ready=%b stall=%b we=%b fv=%b want 0 1 0 0", r, s, w, fv);
    end
    for (int i = 0; i < D; i++) begin
      cyc(0, 1, 32'h5555_AAAA, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (b !== 1'b1 || r !== 1'b0 || w !== 1'b1 || ad !== A'(i) || s !== 1'b1 || fv !== 1'b0) begin
        n_fail++; $display("FAIL clear_sweep%0d got busy=%b ready=%b we=%b addr=%0d stall=%b fv=%b want 1 0 1 %0d 1 0", i, b, r, w, ad, s, fv, i);
      end
      ref_mem[i] = 32'h0;
    end
    cyc(0, 1, 32'h5555_AAAA, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (b !== 1'b0 || r !== 1'b1 || ad !== A'(ref_ptr)) begin
      n_fail++; $display("FAIL clear_resume got busy=%b ready=%b addr=%0d want 0 1 %0d", b, r, ad, ref_ptr);
    end
    ref_load(32'h5555_AAAA, 1'b0);
    cyc(0, 0, 0, 0, 1, 32'(ref_ptr * 4), r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fv !== 1'b1 || fi !== 32'h0) begin n_fail++; $display("FAIL clear_zeroed got fv=%b instr=%h want 1 0", fv, fi); end
    ref_fi = fi;
  endtask

  task automatic test_reset_mid_sweep();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    cyc(1, 0, 0, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    for (int i = 0; i < 7; i++) cyc(0, 1, 32'h77, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
    @(negedge clk); #1;
    n_checks++; if (mem_addr !== A'(7)) begin n_fail++; $display("FAIL pre_reset_addr got %0d want 7", mem_addr); end
    rst = 1'b0; #1;
    n_checks++; if (busy !== 1'b1 || mem_we !== 1'b0 || fetch_stall !== 1'b1 || ld_ready !== 1'b0 || fetch_valid !== 1'b0 || fetch_instr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset got busy=%b we=%b stall=%b ready=%b fv=%b instr=%h want 1 0 1 0 0 0", busy, mem_we, fetch_stall, ld_ready, fetch_valid, fetch_instr);
    end
    @(negedge clk) rst = 1'b1; #1;
    n_checks++; if (mem_addr !== A'(0) || busy !== 1'b1) begin n_fail++; $display("FAIL restart_addr got addr=%0d busy=%b want 0 1", mem_addr, busy); end
    for (int i = 1; i < D; i++) begin
      cyc(0, 1, 32'h77, 0, 1, 0, r, s, w, b, ad, wd, fv, fi, e);
      n_checks++; if (ad !== A'(i) || b !== 1'b1) begin n_fail++; $display("FAIL restart_sweep%0d got addr=%0d busy=%b want %0d 1", i, ad, b, i); end
    end
    for (int i = 0; i < D; i++) ref_mem[i] = 32'h0;
    ref_ptr = 0; ref_fi = 32'h0;
    cyc(0, 1, 32'h77, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (r !== 1'b1 || ad !== A'(0)) begin n_fail++; $display("FAIL ptr_after_reset got ready=%b addr=%0d want 1 0", r, ad); end
    ref_load(32'h77, 1'b0);
  endtask

`ifdef IMEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic r, s, w, b, fv, e; logic [A-1:0] ad; logic [31:0] wd, fi;
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0, r, s, w, b, ad, wd, fv, fi, e);
    ref_load(32'hDEAD_BEEF, 1'b0);
    cyc(0, 0, 0, 0, 1, 32'h6, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (ad !== A'(1) || fv !== 1'b1 || fi !== 32'h0 || e !== 1'b1) begin
      n_fail++; $display("FAIL misalign got addr=%0d fv=%b instr=%h err=%b want 1 1 0 1", ad, fv, fi, e);
    end
    cyc(0, 0, 0, 0, 1, 32'h4, r, s, w, b, ad, wd, fv, fi, e);
    n_checks++; if (fv !== 1'b1 || fi !== 32'hDEAD_BEEF || e !== 1'b0) begin
      n_fail++; $display("FAIL aligned_after got fv=%b instr=%h err=%b want 1 deadbeef 0", fv, fi, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_fill();
    test_load_fetch();
    test_conflict();
    test_wrap_rewind();
    test_alias();
    test_random();
    test_clear();
    test_reset_mid_sweep();
`ifdef IMEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_controller.md
Name: imem_controller

Overview:
Sequences and shares the single-port instruction memory (word array, synchronous write, combinational read) of the single-cycle MIPS.
- After reset it walks the whole array writing zeros.
- It then arbitrates each cycle between a program-loader write stream and the fetch stage's PC-driven read requests.
- Fetch results come back registered, with a stall flag toward the PC logic.

Parameters:
DEPTH, 1024, number of 32-bit words in the instruction memory (power of two)
AW, 10, word-address width, equals log2(DEPTH)
NOP_WORD, 32'h0000_0000, instruction returned on a suppressed or errored fetch

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
clear_req  input  1  one-cycle pulse; restarts the zero-fill sweep
ld_valid  input  1  loader has a word on ld_data
ld_data  input  32  instruction word to write
ld_rewind  input  1  reset load pointer to word 0
ld_ready  output  1  loader word accepted this cycle
fetch_req  input  1  fetch stage requests an instruction
fetch_addr  input  32  byte address from PC
fetch_valid  output  1  fetch_instr valid (registered)
fetch_instr  output  32  returned instruction (registered)
fetch_stall  output  1  request not served this cycle; PC must hold
busy  output  1  zero-fill sweep in progress
mem_addr  output  AW  word address to instruction memory
mem_wdata  output  32  write data
mem_we  output  1  write enable
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset (rst=0, async):
  - State=CLEAR, clear counter=0, load pointer=0.
  - Outputs: fetch_valid=0, fetch_instr=NOP_WORD, ld_ready=0, mem_we=0, busy=1, fetch_stall=1.
- State CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr=clear counter; counter increments each cycle.
  - After the write at DEPTH-1, go to SERVE. The sweep lasts DEPTH cycles.
  - busy=1, ld_ready=0, fetch_stall=fetch_req, fetch_valid=0.
- State SERVE, fixed priority, decided combinationally each cycle:
  1. clear_req=1: go to CLEAR, counter=0. No write or fetch is served that cycle; stall if fetch_req.
  2. ld_valid=1: mem_we=1, mem_addr=load pointer, mem_wdata=ld_data, ld_ready=1. Pointer increments and wraps DEPTH-1 to 0. fetch_stall=fetch_req.
  3. fetch_req=1: mem_we=0, mem_addr=fetch_addr[AW+1:2]. Bits above AW+1 are ignored, so addresses alias modulo DEPTH words. Next edge: fetch_instr<=mem_rdata, fetch_valid<=1. fetch_stall=0.
  4. Otherwise: mem_we=0, fetch_valid<=0 next edge, fetch_instr holds.
- Latency: fetch is 1 cycle (request at edge N, data valid after edge N+1). fetch_valid is a single-cycle pulse per served request.
- ld_rewind=1 forces the pointer to 0 at the next edge. If ld_valid is also high that cycle, the write goes to the old pointer and the pointer becomes 0, not old+1.
- Loads and clear_req arriving during CLEAR are not accepted (ld_ready=0). The loader must hold ld_valid.
- Read-after-write: a fetch of a word in the cycle after it was loaded returns the new data.
- Reset mid-sweep or mid-load aborts immediately. The sweep restarts from 0 and the load pointer returns to 0.

Optional Feature:
IMEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_err (1 bit, reset 0).
  - A served fetch with fetch_addr[1:0]!=0 returns fetch_instr=NOP_WORD with fetch_valid=1 and fetch_err=1 in the same registered cycle. Memory is still addressed.
  - fetch_err is otherwise 0.
- Undefined:
  - No fetch_err port.
  - Low address bits are silently ignored.

Test Plan:
- Zero-fill (DEPTH=16): pre-load memory model with 32'hFFFF_FFFF, release rst -> busy=1 for exactly 16 cycles, mem_we=1 at addresses 0..15, then busy=0 and every word reads 0.
- Load then fetch: push 32'h2008_0005, 32'h2009_0003, 32'h0109_5020; then fetch_addr=0,4,8 -> fetch_valid each next cycle, fetch_instr equals the same three words in order.
- Conflict: ld_valid and fetch_req in the same cycle -> ld_ready=1, fetch_stall=1, no fetch_valid next cycle. Next cycle (ld_valid=0) the fetch is served with fetch_stall=0.
- Wrap/rewind: DEPTH=16, load 17 words 0..16 -> word 0 holds 16. Then ld_rewind together with ld_valid(32'hAA) -> 32'hAA written at pointer 1, next write lands at word 0.
- Aliasing: fetch_addr=32'h0000_0044 with DEPTH=16 -> returns word 1.
- Reset/clear mid-operation: drop rst during sweep counter=7 -> outputs at reset values immediately, sweep restarts at 0. clear_req during SERVE -> busy=1 for DEPTH cycles, ld_ready=0 throughout. With IMEM_MISALIGN_TRAP_EN, fetch_addr=32'h6 -> fetch_instr=0, fetch_err=1.
